// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap accumulator stage.
// Holds the default product width, the FSM state encoding, and the helper
// functions that size the tap counter and the accumulator.
package fir_pkg;

    // Default width of the unsigned tap product (13x13 multiplier output)
    localparam int PROD_W_DEF = 26;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Ceiling log2; returns 0 for values <= 1
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Accumulator width large enough that summing taps products never overflows
    function automatic int acc_width(input int prod_w, input int taps);
        return prod_w + clog2(taps);
    endfunction

endpackage

// File: rtl/fir_out_scale.sv
// Combinational output scaler for the FIR tap accumulator.
// Shifts the accumulated sum right by SHIFT and reduces it to OUT_W bits.
// Build option: OUT_SATURATE_EN clamps oversized results to all ones and
// flags them on sat_o; without it the result wraps and sat_o is tied low.
module fir_out_scale #(
    parameter int ACC_W = 29,
    parameter int OUT_W = 16,
    parameter int SHIFT = 10
) (
    input  logic [ACC_W-1:0] acc_sum_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

`ifdef OUT_SATURATE_EN
    // Largest value representable in OUT_W bits, expressed at accumulator width
    localparam logic [ACC_W-1:0] MAX_OUT = ACC_W'({OUT_W{1'b1}});

    logic [ACC_W-1:0] scaled;

    // Shift, then clamp anything that does not fit in the output width
    always_comb begin
        scaled = acc_sum_i >> SHIFT;
        sat_o  = (scaled > MAX_OUT);
        data_o = sat_o ? {OUT_W{1'b1}} : scaled[OUT_W-1:0];
    end
`else
    // Shift, then keep only the low OUT_W bits (modular wrap)
    always_comb begin
        data_o = OUT_W'(acc_sum_i >> SHIFT);
        sat_o  = 1'b0;
    end
`endif

endmodule

// File: rtl/fir_tap_accum.sv
// FIR tap accumulator: sums TAPS consecutive unsigned products, scales the
// sum and offers it downstream on a valid/ready handshake.
// Build option: OUT_SATURATE_EN selects saturating output (see fir_out_scale);
// the default build wraps.
module fir_tap_accum
    import fir_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int TAPS   = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int ACC_W = acc_width(PROD_W, TAPS);
    localparam int CNT_W = clog2(TAPS);
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q, out_sat_d;

    logic             accept;
    logic [ACC_W-1:0] sum;
    logic [OUT_W-1:0] scaled_data;
    logic             scaled_sat;

    // Inputs are refused only while a finished sample waits downstream
    assign in_ready = (state_q != ST_HOLD);
    assign accept   = in_valid & in_ready;

    // Running sum including the product on the input this cycle
    assign sum = acc_q + ACC_W'(in_prod);

    fir_out_scale #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_out_scale (
        .acc_sum_i (sum),
        .data_o    (scaled_data),
        .sat_o     (scaled_sat)
    );

    // Next-state logic: FSM, tap counter, accumulator and output capture
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;

        if (clear) begin
            // Flush wins over every transition; the last sample value is kept
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        acc_d   = ACC_W'(in_prod);
                        cnt_d   = CNT_W'(1);
                        state_d = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (accept) begin
                        if (cnt_q == LAST_TAP) begin
                            // Final tap: capture the scaled sum including this product
                            out_data_d  = scaled_data;
                            out_sat_d   = scaled_sat;
                            out_valid_d = 1'b1;
                            acc_d       = '0;
                            cnt_d       = '0;
                            state_d     = ST_HOLD;
                        end else begin
                            acc_d = sum;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Output stays stable until downstream takes it
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_fir_tap_accum.sv
// Self-checking bench for fir_tap_accum (default parameters).
// Table-driven directed packets, hand-written clear/reset sequences, and
// randomized packets checked against a sum-then-scale reference model.
module tb_fir_tap_accum;

`ifdef OUT_SATURATE_EN
    localparam bit SAT_MODE = 1'b1;
`else
    localparam bit SAT_MODE = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] in_prod;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;

    int checks = 0;
    int errors = 0;

    fir_tap_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [25:0] prod;
        int          gaps;
        int          hold;
        logic [15:0] exp_data;
        logic        exp_sat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer sum of the eight products, shifted, then fit to 16 bits
    task automatic ref_out(input logic [25:0] p [8], output logic [15:0] d, output logic s);
        longint total;
        longint scaled;
        total = 0;
        for (int i = 0; i < 8; i++) total += longint'(p[i]);
        scaled = total / 1024;
        if (SAT_MODE && scaled > 65535) begin
            d = 16'hFFFF;
            s = 1'b1;
        end else begin
            d = 16'(scaled % 65536);
            s = 1'b0;
        end
    endtask

    // Drive eight products with 'gaps' bubbles between them, check the result,
    // hold it 'hold' cycles, then hand it off. hold < 0 leaves the DUT in HOLD.
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_packet(input string tag, input logic [25:0] p [8], input int gaps,
                              input int hold, input logic [15:0] ed, input logic es);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) chk({tag, "_in_ready_idle"}, in_ready, 1);
            in_valid = 1'b1;
            in_prod  = p[i];
            @(posedge clk); #1;
            if (i == 6) chk({tag, "_not_early"}, out_valid, 0);
            if (i < 7 && gaps > 0) begin
                in_valid = 1'b0;
                in_prod  = 26'($urandom);
                repeat (gaps) begin
                    @(posedge clk); #1;
                end
                if (i == 6) chk({tag, "_bubble_no_out"}, out_valid, 0);
            end
        end
        // Junk offered while holding must never be accepted
        in_valid = 1'b1;
        in_prod  = 26'h3FFFFFF;
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_out_data"}, out_data, ed);
        chk({tag, "_out_sat"}, out_sat, es);
        chk({tag, "_in_ready_hold"}, in_ready, 0);
        if (hold >= 0) begin
            out_ready = 1'b0;
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
                chk({tag, "_held_valid"}, out_valid, 1);
                chk({tag, "_held_data"}, out_data, ed);
                chk({tag, "_held_in_ready"}, in_ready, 0);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk({tag, "_handoff_valid"}, out_valid, 0);
            chk({tag, "_handoff_in_ready"}, in_ready, 1);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    logic [25:0] pk [8];
    logic [15:0] ed;
    logic        es;

    initial begin
        // Directed table
        vecs[0] = '{"t1_basic",     26'd1024,     0, 0, 16'd8,     1'b0};
        vecs[1] = '{"t2_backpress", 26'd1024,     0, 5, 16'd8,     1'b0};
        vecs[2] = '{"t3_overflow",  26'h0800000,  0, 1, SAT_MODE ? 16'hFFFF : 16'h0000, SAT_MODE};
        vecs[3] = '{"t5_bubbles",   26'd1024,     1, 0, 16'd8,     1'b0};
        vecs[4] = '{"t_2048",       26'd2048,     0, 2, 16'd16,    1'b0};
        vecs[5] = '{"t_zero",       26'd0,        0, 0, 16'd0,     1'b0};
        vecs[6] = '{"t_max",        26'h3FFFFFF,  0, 1, 16'hFFFF,  SAT_MODE};
        vecs[7] = '{"t_8191",       26'd8191,     2, 0, 16'd63,    1'b0};

        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_sat", out_sat, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < 8; i++) pk[i] = vecs[v].prod;
            run_packet(vecs[v].name, pk, vecs[v].gaps, vecs[v].hold,
                       vecs[v].exp_data, vecs[v].exp_sat);
        end

        // Test 4: partial packet flushed by clear (clear also beats a same-cycle accept)
        in_valid = 1'b1;
        in_prod  = 26'd5000;
        repeat (3) begin
            @(posedge clk); #1;
        end
        clear = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("t4_after_clear_valid", out_valid, 0);
        for (int i = 0; i < 8; i++) pk[i] = 26'd2048;
        run_packet("t4_flushed", pk, 0, 0, 16'd16, 1'b0);

        // Clear during HOLD with out_ready high: drops valid, keeps data
        for (int i = 0; i < 8; i++) pk[i] = 26'd1024;
        run_packet("clr_hold", pk, 0, -1, 16'd8, 1'b0);
        clear     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("clr_hold_valid", out_valid, 0);
        chk("clr_hold_data_kept", out_data, 8);
        chk("clr_hold_in_ready", in_ready, 1);
        for (int i = 0; i < 8; i++) pk[i] = 26'd3072;
        run_packet("after_clr", pk, 0, 0, 16'd24, 1'b0);

        // Test 6: asynchronous reset while holding an output
        for (int i = 0; i < 8; i++) pk[i] = 26'd1024;
        run_packet("rst_hold", pk, 0, -1, 16'd8, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid, 0);
        chk("rst_async_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_packet("t6_after_rst", pk, 0, 0, 16'd8, 1'b0);

        // Reset in the middle of accumulation: partial beats must be lost
        in_valid = 1'b1;
        in_prod  = 26'd40000;
        repeat (4) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_mid_acc_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_packet("after_rst_acc", pk, 0, 0, 16'd8, 1'b0);

        // Randomized packets against the reference model
        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 8; i++) begin
                if (r % 3 == 0) pk[i] = 26'($urandom);
                else if (r % 3 == 1) pk[i] = 26'($urandom_range(0, 600000));
                else pk[i] = 26'($urandom_range(0, 9000));
            end
            ref_out(pk, ed, es);
            run_packet($sformatf("rnd%0d", r), pk, int'($urandom_range(0, 2)),
                       int'($urandom_range(0, 3)), ed, es);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
